// File: rtl/axi2core_pkg.sv
// Shared types and constants for the AXI4-slave to memory-port bridge.
// Holds the FSM state encoding, AXI response/burst codes and the word stride.
// No logic lives here; every bridge file imports it.
package axi2core_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RD_RESP,
    WR_DATA,
    WR_REQ,
    WR_WAIT,
    WR_RESP
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  localparam int unsigned WORD_STRIDE = 4;

endpackage

// File: rtl/axi2core_addr_gen.sv
// Beat address register: loads a word-aligned base and steps it per burst type.
// Latency: loaded/advanced address is visible the cycle after load/advance.
// Backpressure: none; the caller only pulses advance between memory accesses.
module axi2core_addr_gen
  import axi2core_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic [1:0]    load_burst,
  input  logic          advance,
  output logic [AW-1:0] addr
);

  logic [AW-1:0] addr_q;
  logic [1:0]    burst_q;

  // WRAP steps like INCR (it is flagged as an error elsewhere); FIXED and the
  // reserved code both hold the address. INCR wraps naturally modulo 2^AW.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      burst_q <= FIXED;
    end else if (load) begin
      addr_q  <= {load_addr[AW-1:2], 2'b00};
      burst_q <= load_burst;
    end else if (advance && ((burst_q == INCR) || (burst_q == WRAP))) begin
      addr_q  <= addr_q + AW'(WORD_STRIDE);
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/axi2core.sv
// AXI4 slave replayed as word-wide req/gnt/rvalid accesses, one transaction at a time.
// Latency: AR->R 3 cycles, AW->B 4 cycles (W present, immediate gnt, rvalid 1 cycle later).
// Backpressure: mem_req held until gnt; R/B held until ready; AR/AW stalled while busy.
module axi2core
  import axi2core_pkg::*;
#(
  parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI4_DATA_WIDTH    = 32,
  parameter int unsigned AXI4_ID_WIDTH      = 16,
  parameter int unsigned AXI4_USER_WIDTH    = 10
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [AXI4_ID_WIDTH-1:0]      aw_id_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr_i,
  input  logic [7:0]                    aw_len_i,
  input  logic [1:0]                    aw_burst_i,
  input  logic                          aw_valid_i,
  output logic                          aw_ready_o,
  input  logic [AXI4_DATA_WIDTH-1:0]    w_data_i,
  input  logic [3:0]                    w_strb_i,
  input  logic                          w_last_i,
  input  logic                          w_valid_i,
  output logic                          w_ready_o,
  output logic [AXI4_ID_WIDTH-1:0]      b_id_o,
  output logic [1:0]                    b_resp_o,
  output logic [AXI4_USER_WIDTH-1:0]    b_user_o,
  output logic                          b_valid_o,
  input  logic                          b_ready_i,
  input  logic [AXI4_ID_WIDTH-1:0]      ar_id_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] ar_addr_i,
  input  logic [7:0]                    ar_len_i,
  input  logic [1:0]                    ar_burst_i,
  input  logic                          ar_valid_i,
  output logic                          ar_ready_o,
  output logic [AXI4_ID_WIDTH-1:0]      r_id_o,
  output logic [AXI4_DATA_WIDTH-1:0]    r_data_o,
  output logic [1:0]                    r_resp_o,
  output logic                          r_last_o,
  output logic [AXI4_USER_WIDTH-1:0]    r_user_o,
  output logic                          r_valid_o,
  input  logic                          r_ready_i,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [AXI4_ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [3:0]                    mem_be_o,
  output logic [AXI4_DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_rvalid_i,
  input  logic [AXI4_DATA_WIDTH-1:0]    mem_rdata_i
);

`ifndef SYNTHESIS
  if (AXI4_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axi2core: AXI4_DATA_WIDTH must be 32");
  end
`endif

  state_e                          state_q, state_d;
  logic                            last_was_read_q;
  logic                            err_q;
  logic [AXI4_ID_WIDTH-1:0]        id_q;
  logic [7:0]                      len_q, beat_q;
  logic [AXI4_DATA_WIDTH-1:0]      rdata_q, wdata_q;
  logic [3:0]                      be_q;
  logic                            grant_rd, grant_wr, accept, last_beat, addr_adv;
  logic [AXI4_ADDRESS_WIDTH-1:0]   load_addr;
  logic [1:0]                      load_burst;

  // Read wins when alone or when the previous winner was a write.
  assign grant_rd   = (state_q == IDLE) && ar_valid_i && (!aw_valid_i || !last_was_read_q);
  assign grant_wr   = (state_q == IDLE) && aw_valid_i && !grant_rd;
  assign accept     = grant_rd || grant_wr;
  assign last_beat  = (beat_q == len_q);
  assign load_addr  = grant_rd ? ar_addr_i  : aw_addr_i;
  assign load_burst = grant_rd ? ar_burst_i : aw_burst_i;

  axi2core_addr_gen #(
    .AW (AXI4_ADDRESS_WIDTH)
  ) u_addr_gen (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load       (accept),
    .load_addr  (load_addr),
    .load_burst (load_burst),
    .advance    (addr_adv),
    .addr       (mem_addr_o)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and beat-advance decode.
  always_comb begin
    state_d  = state_q;
    addr_adv = 1'b0;
    unique case (state_q)
      IDLE:    if (grant_rd) state_d = RD_REQ;
               else if (grant_wr) state_d = WR_DATA;
      RD_REQ:  if (mem_gnt_i) state_d = RD_WAIT;
      RD_WAIT: if (mem_rvalid_i) state_d = RD_RESP;
      RD_RESP: if (r_ready_i) begin
                 if (last_beat) state_d = IDLE;
                 else begin
                   addr_adv = 1'b1;
                   state_d  = RD_REQ;
                 end
               end
      WR_DATA: if (w_valid_i) state_d = WR_REQ;
      WR_REQ:  if (mem_gnt_i) state_d = WR_WAIT;
      WR_WAIT: if (mem_rvalid_i) begin
                 if (last_beat) state_d = WR_RESP;
                 else begin
                   addr_adv = 1'b1;
                   state_d  = WR_DATA;
                 end
               end
      WR_RESP: if (b_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction context, beat counter, error flag and captured data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_was_read_q <= 1'b0;
      err_q           <= 1'b0;
      id_q            <= '0;
      len_q           <= '0;
      beat_q          <= '0;
      rdata_q         <= '0;
      wdata_q         <= '0;
      be_q            <= '0;
    end else begin
      if (accept) begin
        last_was_read_q <= grant_rd;
        id_q            <= grant_rd ? ar_id_i  : aw_id_i;
        len_q           <= grant_rd ? ar_len_i : aw_len_i;
        beat_q          <= '0;
        // WRAP and the reserved encoding are both unsupported.
        err_q           <= load_burst[1];
      end
      if (addr_adv) beat_q <= beat_q + 8'd1;
      if ((state_q == RD_WAIT) && mem_rvalid_i) rdata_q <= mem_rdata_i;
      if ((state_q == WR_DATA) && w_valid_i) begin
        wdata_q <= w_data_i;
        be_q    <= w_strb_i;
        // Beat count follows len; a misplaced w_last only poisons the response.
        if (w_last_i != last_beat) err_q <= 1'b1;
      end
    end
  end

  assign ar_ready_o  = grant_rd;
  assign aw_ready_o  = grant_wr;
  assign w_ready_o   = (state_q == WR_DATA);
  assign mem_req_o   = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign mem_we_o    = (state_q == WR_REQ);
  assign mem_be_o    = (state_q == WR_REQ) ? be_q : 4'hF;
  assign mem_wdata_o = wdata_q;
  assign r_valid_o   = (state_q == RD_RESP);
  assign r_data_o    = rdata_q;
  assign r_id_o      = id_q;
  assign r_last_o    = (state_q == RD_RESP) && last_beat;
  assign r_resp_o    = err_q ? SLVERR : OKAY;
  assign r_user_o    = '0;
  assign b_valid_o   = (state_q == WR_RESP);
  assign b_id_o      = id_q;
  assign b_resp_o    = err_q ? SLVERR : OKAY;
  assign b_user_o    = '0;

endmodule
